// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the single-port memory arbiter.
// Optional statistics are enabled with MEM_ARB_STATS_EN (see mem_port_arbiter).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RD_I,
        ARB_RD_D,
        ARB_RD_IO
    } arb_state_t;

    localparam logic [15:0] IO_BASE = 16'hFFF0;

    // Byte address falls inside the RAM window when every bit above the word index is zero.
    function automatic logic in_ram(input logic [31:0] addr, input int unsigned abits);
        return (addr >> (abits + 1)) == '0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating fetch-starvation counter with synchronous clear and limit flag.
// Part of mem_port_arbiter (MEM_ARB_STATS_EN does not affect this block).
module arb_starve_ctr #(
    parameter int unsigned LIMIT = 3,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             at_limit
);
    import mem_arb_pkg::*;

    assign at_limit = (cnt == WIDTH'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the data stage.
// Define MEM_ARB_STATS_EN to add the FSTALLCNT / DCONFCNT statistics outputs.
module mem_port_arbiter #(
    parameter int unsigned DBITS      = 16,
    parameter int unsigned ABITS      = 12,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IREQ,
    input  logic [DBITS-1:0] IADDR,
    output logic             IGNT,
    output logic             IVALID,
    output logic [DBITS-1:0] IRDATA,
    input  logic             DREQ,
    input  logic             DWE,
    input  logic [DBITS-1:0] DADDR,
    input  logic [DBITS-1:0] DDIN,
    output logic             DGNT,
    output logic             DVALID,
    output logic [DBITS-1:0] DRDATA,
    output logic             DIO,
    input  logic [DBITS-1:0] IORDATA,
    output logic [ABITS-1:0] MADDR,
    output logic             MWE,
    output logic [DBITS-1:0] MDIN,
    input  logic [DBITS-1:0] MDOUT,
    output logic             FSTALL
`ifdef MEM_ARB_STATS_EN
   ,output logic [15:0]      FSTALLCNT,
    output logic [15:0]      DCONFCNT
`endif
);
    import mem_arb_pkg::*;

    logic             d_in_ram;
    logic             d_ram_req;
    logic             d_io_req;
    logic             starve_hit;
    logic             ignt;
    logic             dgnt_ram;
    logic             io_load;
    logic [3:0]       starve;
    logic [ABITS-1:0] maddr_c;
    logic [ABITS-1:0] maddr_q;
    logic [DBITS-1:0] io_q;
    logic             fetch_also_q;
    logic             unused_iaddr;
    arb_state_t       state;
    arb_state_t       state_next;

    assign unused_iaddr = ^{IADDR[DBITS-1:ABITS+1], IADDR[0]};

    // Every combinational output is gated by RESET_N so reset forces them low immediately.
    assign d_in_ram  = in_ram(32'(DADDR), ABITS);
    assign d_ram_req = RESET_N & DREQ & d_in_ram;
    assign d_io_req  = RESET_N & DREQ & ~d_in_ram;
    assign dgnt_ram  = d_ram_req & ~starve_hit;
    assign ignt      = RESET_N & IREQ & (~d_ram_req | starve_hit);
    assign io_load   = d_io_req & ~DWE;

    assign IGNT   = ignt;
    assign DGNT   = dgnt_ram | d_io_req;
    assign DIO    = d_io_req;
    assign FSTALL = RESET_N & IREQ & ~ignt;

    always_comb begin
        maddr_c = maddr_q;
        if (ignt) begin
            maddr_c = IADDR[ABITS:1];
        end else if (dgnt_ram) begin
            maddr_c = DADDR[ABITS:1];
        end
    end

    assign MADDR = maddr_c;
    assign MWE   = dgnt_ram & DWE;
    assign MDIN  = (dgnt_ram & DWE) ? DDIN : '0;

    arb_starve_ctr #(
        .LIMIT (STARVE_MAX),
        .WIDTH (4)
    ) u_starve (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .clr      (ignt | ~IREQ),
        .inc      (dgnt_ram & IREQ),
        .cnt      (starve),
        .at_limit (starve_hit)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            maddr_q      <= '0;
            io_q         <= '0;
            fetch_also_q <= 1'b0;
        end else begin
            maddr_q      <= maddr_c;
            fetch_also_q <= io_load & ignt;
            if (io_load) begin
                io_q <= IORDATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An I/O load granted alongside a fetch goes to RD_IO; fetch_also_q carries the fetch return.
    always_comb begin
        state_next = ARB_IDLE;
        if (io_load) begin
            state_next = ARB_RD_IO;
        end else if (ignt) begin
            state_next = ARB_RD_I;
        end else if (dgnt_ram && !DWE) begin
            state_next = ARB_RD_D;
        end
    end

    always_comb begin
        IVALID = 1'b0;
        IRDATA = '0;
        DVALID = 1'b0;
        DRDATA = '0;
        unique case (state)
            ARB_RD_I: begin
                IVALID = 1'b1;
                IRDATA = MDOUT;
            end
            ARB_RD_D: begin
                DVALID = 1'b1;
                DRDATA = MDOUT;
            end
            ARB_RD_IO: begin
                DVALID = 1'b1;
                DRDATA = io_q;
                if (fetch_also_q) begin
                    IVALID = 1'b1;
                    IRDATA = MDOUT;
                end
            end
            default: begin
                IVALID = 1'b0;
            end
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            FSTALLCNT <= '0;
            DCONFCNT  <= '0;
        end else begin
            if (FSTALL && FSTALLCNT != '1) begin
                FSTALLCNT <= FSTALLCNT + 16'd1;
            end
            if (d_ram_req && starve_hit && DCONFCNT != '1) begin
                DCONFCNT <= DCONFCNT + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data/instruction memory between two requesters: the instruction-fetch stage and the data stage (LW/SW).
- Data accesses take priority. A starvation counter forces one fetch grant after STARVE_MAX consecutive data grants.
- Data addresses outside the RAM window bypass memory and are handed to the I/O decoder (keys, switches, HEX, LEDs).
- Lets the pipeline use a 1-port RAM in place of the dual-port MemArray.

Parameters:
- DBITS, 16, data and address width in bits.
- ABITS, 12, word-address bits into the RAM; RAM is indexed by ADDR[ABITS:1].
- STARVE_MAX, 3, maximum consecutive data grants while IREQ is waiting; range 1..15.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IREQ  in  1  fetch request; held with IADDR stable until IGNT.
- IADDR  in  DBITS  fetch byte address.
- IGNT  out  1  fetch granted this cycle.
- IVALID  out  1  IRDATA valid; one cycle after IGNT.
- IRDATA  out  DBITS  fetched word.
- DREQ  in  1  data request; held with DWE, DADDR, DDIN stable until DGNT.
- DWE  in  1  1 = store, 0 = load.
- DADDR  in  DBITS  data byte address.
- DDIN  in  DBITS  store data.
- DGNT  out  1  data request granted this cycle.
- DVALID  out  1  DRDATA valid (loads only); one cycle after DGNT.
- DRDATA  out  DBITS  loaded word, from RAM or I/O.
- DIO  out  1  this cycle's data access targets I/O space; combinational with DGNT.
- IORDATA  in  DBITS  read value from the I/O decoder.
- MADDR  out  ABITS  RAM word address.
- MWE  out  1  RAM write enable.
- MDIN  out  DBITS  RAM write data.
- MDOUT  in  DBITS  RAM read data; valid one cycle after address.
- FSTALL  out  1  = IREQ & ~IGNT; freezes the PC.

Behaviour:
- Window decode: RAM access iff DADDR[DBITS-1:ABITS+1]==0. Otherwise DIO=1, MWE stays 0, and no RAM cycle is consumed.
- IADDR is always treated as a RAM address; its upper bits are ignored.
- Grant logic is combinational from the inputs and registered state.
  - DREQ & RAM & starve<STARVE_MAX: DGNT.
  - IREQ & (no RAM data request, or starve==STARVE_MAX): IGNT.
  - A data I/O access gets DGNT and an IREQ gets IGNT in the same cycle; they do not conflict.
  - A RAM data grant and IGNT are never asserted together.
- MADDR/MWE/MDIN come from the granted RAM requester. When idle, MADDR holds its last value and MWE=0.
- Starve counter:
  - Increments when DGNT is to RAM while IREQ=1.
  - Clears on IGNT or when IREQ=0.
  - Saturates at STARVE_MAX.
- Read-return FSM, registered, states IDLE / RD_I / RD_D / RD_IO:
  - Next state from this cycle's grant type: RD_I if fetch, RD_D if RAM load, RD_IO if I/O load, IDLE otherwise.
  - Stores return to IDLE; they produce no DVALID.
  - A simultaneous I/O load plus fetch returns both: IVALID with MDOUT and DVALID with the registered IORDATA.
- Valid strobes:
  - IVALID=1 in RD_I with IRDATA=MDOUT.
  - DVALID=1 in RD_D with DRDATA=MDOUT.
  - DVALID=1 in RD_IO with DRDATA = IORDATA captured at grant.
- Latency:
  - Grant to data is 1 cycle.
  - Throughput is one RAM access per cycle.
- Reset (async assert, sync deassert in the caller):
  - IGNT=DGNT=IVALID=DVALID=MWE=DIO=0.
  - IRDATA=DRDATA=0, MADDR=0, starve=0, state=IDLE.
- Reset asserted mid-read drops the pending IVALID/DVALID; requesters must re-issue.
- Requests dropped before grant are simply lost; no error is raised.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined:
  - Extra outputs FSTALLCNT[15:0] and DCONFCNT[15:0], both saturating and cleared by reset.
  - FSTALLCNT counts FSTALL cycles.
  - DCONFCNT counts cycles where the starve limit denied DREQ.
  - A DREQ denied by the starve limit gets DGNT=0 and must be held.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {ARB_IDLE, ARB_RD_I, ARB_RD_D, ARB_RD_IO};
  - I/O base constant IO_BASE=16'hFFF0;
  - helper function in_ram(addr).
- One sub-module, arb_starve_ctr: a saturating counter with clear and limit output.

Test Plan:
- IREQ=1 at IADDR=16'h0200, DREQ=0, RAM[0x100]=16'h1234 -> IGNT that cycle; next cycle IVALID=1, IRDATA=16'h1234; FSTALL=0.
- IREQ and DREQ (load, DADDR=16'h0010) continuous, STARVE_MAX=3 -> DGNT pattern D,D,D,I repeating; FSTALL high on 3 of every 4 cycles.
- DREQ store DADDR=16'h0020, DDIN=16'hBEEF -> MWE=1, MADDR=12'h010, MDIN=16'hBEEF, no DVALID; a later load of 16'h0020 returns 16'hBEEF.
- DREQ load DADDR=16'hFFF2 with IORDATA=16'h0155, plus IREQ -> DIO=1, DGNT=1 and IGNT=1 in the same cycle, MWE=0; next cycle DVALID with DRDATA=16'h0155 and IVALID.
- RESET_N pulled low the cycle after IGNT -> IVALID stays 0; all outputs zero immediately (asynchronously).
- With MEM_ARB_STATS_EN, scenario 2 run for 40 cycles -> FSTALLCNT=30, DCONFCNT=10.
